// File: rtl/stall_requester.sv
// stall_requester
//   Queues stall requests in a 2-entry FIFO and hands them, one at a time,
//   to a downstream stall counter. A request is handed over with a one-cycle
//   start pulse. The block then waits for the counter's PC-enable to drop,
//   which means the stall has started, and to rise again, which means it has
//   ended. If PC-enable never drops within TIMEOUT cycles the attempt is
//   abandoned and a sticky error flag is raised.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rstN         in   synchronous active-low reset
//   reqValid     in   a stall request is presented this cycle
//   reqCycles    in   requested stall length [DELAY_W]
//   reqReady     out  FIFO not full, so a request can be accepted
//   pcEn         in   PC-enable from the stall counter (0 = stalling)
//   delayEn      out  one-cycle stall-start pulse
//   delayLen     out  stall length, valid with delayEn, otherwise 0
//   busy         out  FIFO non-empty or FSM not idle
//   errTimeout   out  sticky: pcEn failed to fall within TIMEOUT cycles
//   issuedCount  out  completed stalls, wraps 255 -> 0
module stall_requester #(
  parameter int DELAY_W = 3,
  parameter int TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               reqValid,
  input  logic [DELAY_W-1:0] reqCycles,
  output logic               reqReady,
  input  logic               pcEn,
  output logic               delayEn,
  output logic [DELAY_W-1:0] delayLen,
  output logic               busy,
  output logic               errTimeout,
  output logic [7:0]         issuedCount
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_ZERO  = TW'(0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t             state_r;
  state_t             nextState_s;

  logic [DELAY_W-1:0] fifoMem_r [2];
  logic               wrPtr_r;
  logic               rdPtr_r;
  logic [1:0]         fifoCount_r;
  logic [1:0]         countNext_s;
  logic               push_s;
  logic               pop_s;
  logic               notEmpty_s;
  logic               headNonZero_s;
  logic [DELAY_W-1:0] head_s;

  logic [TW-1:0]      toCnt_r;
  logic [TW-1:0]      toCntNext_s;
  logic               errNext_s;
  logic [7:0]         issuedNext_s;

  // Ready depends only on stored occupancy, so a pop on the same edge
  // cannot open a slot for the request presented this cycle.
  assign reqReady      = (fifoCount_r != 2'd2);
  assign push_s        = reqValid & reqReady;
  assign notEmpty_s    = (fifoCount_r != 2'd0);
  assign head_s        = fifoMem_r[rdPtr_r];
  assign headNonZero_s = notEmpty_s & (head_s != {DELAY_W{1'b0}});

  // FIFO occupancy after this edge; push+pop leaves it unchanged.
  always_comb begin
    countNext_s = fifoCount_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = fifoCount_r + 2'd1;
      2'b01:   countNext_s = fifoCount_r - 2'd1;
      default: countNext_s = fifoCount_r;
    endcase
  end

  // Next state, FIFO pop, timeout counter, error flag and completion count.
  always_comb begin
    nextState_s  = state_r;
    pop_s        = 1'b0;
    toCntNext_s  = toCnt_r;
    errNext_s    = errTimeout;
    issuedNext_s = issuedCount;
    case (state_r)
      IDLE: begin
        if (!notEmpty_s) begin
          nextState_s = IDLE;
        end else if (!headNonZero_s) begin
          // Zero-length request: drop it without a pulse.
          pop_s       = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = ISSUE;
        end
      end
      ISSUE: begin
        pop_s       = 1'b1;
        toCntNext_s = TO_ZERO;
        nextState_s = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!pcEn) begin
          nextState_s = WAIT_HIGH;
        end else begin
          toCntNext_s = toCnt_r + TO_ONE;
          if ((toCnt_r + TO_ONE) == TO_LIMIT) begin
            errNext_s   = 1'b1;
            nextState_s = IDLE;
          end else begin
            nextState_s = WAIT_LOW;
          end
        end
      end
      WAIT_HIGH: begin
        if (pcEn) begin
          issuedNext_s = issuedCount + 8'd1;
          if (headNonZero_s) begin
            nextState_s = ISSUE;
          end else begin
            nextState_s = IDLE;
          end
        end else begin
          nextState_s = WAIT_HIGH;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      fifoMem_r[0] <= {DELAY_W{1'b0}};
      fifoMem_r[1] <= {DELAY_W{1'b0}};
      wrPtr_r      <= 1'b0;
      rdPtr_r      <= 1'b0;
      fifoCount_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifoMem_r[wrPtr_r] <= reqCycles;
      end
      wrPtr_r     <= wrPtr_r ^ push_s;
      rdPtr_r     <= rdPtr_r ^ pop_s;
      fifoCount_r <= countNext_s;
    end
  end

  // FSM state, timeout counter and status registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r     <= IDLE;
      toCnt_r     <= TO_ZERO;
      errTimeout  <= 1'b0;
      issuedCount <= 8'd0;
    end else begin
      state_r     <= nextState_s;
      toCnt_r     <= toCntNext_s;
      errTimeout  <= errNext_s;
      issuedCount <= issuedNext_s;
    end
  end

  // Registered pulse/length/busy, computed from next-cycle state. The head
  // is never popped on an edge that enters ISSUE, so the current head is
  // also the head seen during ISSUE.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      delayEn  <= 1'b0;
      delayLen <= {DELAY_W{1'b0}};
      busy     <= 1'b0;
    end else begin
      delayEn  <= (nextState_s == ISSUE);
      delayLen <= (nextState_s == ISSUE) ? head_s : {DELAY_W{1'b0}};
      busy     <= (countNext_s != 2'd0) || (nextState_s != IDLE);
    end
  end

endmodule

// File: tb/tb_stall_requester.sv
// Randomized + directed bench for stall_requester, checked every cycle
// against a queue-based reference model.
module tb_stall_requester;

  localparam int DW = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          reqValid;
  logic [DW-1:0] reqCycles;
  logic          reqReady;
  logic          pcEn;
  logic          delayEn;
  logic [DW-1:0] delayLen;
  logic          busy;
  logic          errTimeout;
  logic [7:0]    issuedCount;

  stall_requester #(.DELAY_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqCycles(reqCycles),
    .reqReady(reqReady), .pcEn(pcEn), .delayEn(delayEn), .delayLen(delayLen),
    .busy(busy), .errTimeout(errTimeout), .issuedCount(issuedCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: queue + phase (0 idle, 1 pulse, 2 wait low, 3 wait high)
  int mq[$];
  int mPhase = 0;
  int mLowWait = 0;
  int mErr = 0;
  int mIssued = 0;
  int mTotal = 0;

  // observation log
  int edgeNo = 0;
  int pulseCnt = 0;
  int pulseLens[$];
  int pulseEdge = -1;
  int errEdge = -1;
  int lowStart = -1;
  int lowEnd = -2;
  int lowLen = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edgeNo);
    end
  endtask

  task automatic modelStep(input bit v, input int c, input bit pc, input bit r);
    int  nPhase;
    bit  pop;
    bit  acc;
    if (!r) begin
      mq.delete();
      mPhase = 0; mLowWait = 0; mErr = 0; mIssued = 0;
    end else begin
      acc = v && (mq.size() < 2);
      pop = 0;
      nPhase = mPhase;
      case (mPhase)
        0: if (mq.size() > 0) begin
             if (mq[0] == 0) pop = 1; else nPhase = 1;
           end
        1: begin pop = 1; mLowWait = 0; nPhase = 2; end
        2: if (!pc) nPhase = 3;
           else begin
             mLowWait++;
             if (mLowWait == TO) begin mErr = 1; nPhase = 0; end
           end
        3: if (pc) begin
             mIssued = (mIssued + 1) % 256;
             mTotal++;
             nPhase = (mq.size() > 0 && mq[0] != 0) ? 1 : 0;
           end
        default: nPhase = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(c);
      mPhase = nPhase;
    end
  endtask

  // Emulated stall counter: pcEn low for lowLen cycles, one cycle after each pulse.
  function automatic bit autoPc();
    return !(edgeNo >= lowStart && edgeNo <= lowEnd);
  endfunction

  task automatic clearLog();
    pulseCnt = 0;
    pulseLens.delete();
    pulseEdge = -1;
    errEdge = -1;
  endtask

  task automatic tick(input bit v, input int c, input bit pc, input bit r);
    int cm;
    cm = c & ((1 << DW) - 1);
    reqValid  = v;
    reqCycles = DW'(cm);
    pcEn      = pc;
    rstN      = r;
    modelStep(v, cm, pc, r);
    @(posedge clk);
    #1;
    edgeNo++;
    if (delayEn === 1'b1) begin
      pulseCnt++;
      pulseLens.push_back(int'(delayLen));
      if (pulseEdge < 0) pulseEdge = edgeNo;
    end
    if (errTimeout === 1'b1 && errEdge < 0) errEdge = edgeNo;
    if (mPhase == 1) begin
      lowStart = edgeNo + 1;
      lowEnd   = edgeNo + lowLen;
    end
    chk("ready",  reqReady,    (mq.size() < 2) ? 1 : 0);
    chk("dlyEn",  delayEn,     (mPhase == 1) ? 1 : 0);
    chk("dlyLen", delayLen,    (mPhase == 1) ? mq[0] : 0);
    chk("busy",   busy,        (mq.size() != 0 || mPhase != 0) ? 1 : 0);
    chk("err",    errTimeout,  mErr);
    chk("issued", issuedCount, mIssued);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushEdge;
    int target;
    reqValid = 1'b0; reqCycles = '0; pcEn = 1'b1; rstN = 1'b0;

    // reset and release
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("rst_ready", reqReady, 1);
    chk("rst_busy",  busy, 0);
    tick(0, 0, 1, 1);

    // single request of 3, pcEn low 3 cycles starting one after the pulse
    clearLog();
    lowLen = 3;
    tick(1, 3, autoPc(), 1);
    pushEdge = edgeNo;
    for (int i = 0; i < 10; i++) tick(0, 0, autoPc(), 1);
    chk("s1_pulses",  pulseCnt, 1);
    chk("s1_len",     (pulseLens.size() > 0) ? pulseLens[0] : -1, 3);
    chk("s1_latency", pulseEdge - pushEdge, 1);
    chk("s1_issued",  issuedCount, 1);
    chk("s1_busy",    busy, 0);

    // queue full: 5, 2, 7 back to back with pcEn held low
    tick(0, 0, 1, 0);
    clearLog();
    tick(1, 5, 0, 1);
    tick(1, 2, 0, 1);
    chk("full_ready", reqReady, 0);
    tick(1, 7, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1);
    chk("full_pulses", pulseCnt, 2);
    chk("full_len0", (pulseLens.size() > 0) ? pulseLens[0] : -1, 5);
    chk("full_len1", (pulseLens.size() > 1) ? pulseLens[1] : -1, 2);
    chk("full_issued", issuedCount, 2);

    // zero-length request followed by 4
    tick(0, 0, 1, 0);
    clearLog();
    lowLen = 2;
    tick(1, 0, autoPc(), 1);
    tick(1, 4, autoPc(), 1);
    for (int i = 0; i < 10; i++) tick(0, 0, autoPc(), 1);
    chk("zero_pulses", pulseCnt, 1);
    chk("zero_len",    (pulseLens.size() > 0) ? pulseLens[0] : -1, 4);
    chk("zero_issued", issuedCount, 1);

    // timeout: pcEn never falls
    tick(0, 0, 1, 0);
    clearLog();
    tick(1, 6, 1, 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 1, 1);
    chk("to_err",     errTimeout, 1);
    chk("to_latency", errEdge - pulseEdge, TO + 1);
    chk("to_issued",  issuedCount, 0);
    chk("to_busy",    busy, 0);
    tick(0, 0, 1, 1);
    chk("to_sticky",  errTimeout, 1);

    // reset while in WAIT_HIGH with two entries queued
    tick(0, 0, 1, 0);
    tick(1, 3, 1, 1);
    tick(1, 5, 1, 1);
    tick(1, 6, 1, 1);
    tick(1, 6, 0, 1);
    chk("mid_queued", reqReady, 0);
    tick(0, 0, 0, 0);
    clearLog();
    chk("mid_busy",   busy, 0);
    chk("mid_err",    errTimeout, 0);
    chk("mid_ready",  reqReady, 1);
    chk("mid_dlyEn",  delayEn, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1);
    chk("mid_nopulse", pulseCnt, 0);

    // 256 completed stalls wrap the counter to 0
    tick(0, 0, 1, 0);
    lowLen = 1;
    target = mTotal + 256;
    for (int i = 0; i < 3000 && mTotal < target; i++) tick(1, 1, autoPc(), 1);
    if (mTotal < target) chk("wrap_budget", mTotal, target);
    chk("wrap_count", issuedCount, 0);
    tick(0, 0, autoPc(), 1);
    tick(0, 0, autoPc(), 1);
    tick(0, 0, autoPc(), 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 1), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stall_requester.md
STALL_REQUESTER -- requirements
Module: stall_requester

Interface
REQ-001 Parameter DELAY_W, default 3: width of the stall-length field; it matches the width of the stall counter's count register.
REQ-002 Parameter TIMEOUT, default 4: the number of cycles to wait for pcEn to fall after a pulse before the attempt is declared lost.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rstN  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 reqValid  input  1: a stall request is presented this cycle.
REQ-006 reqCycles  input  DELAY_W: the requested stall length in cycles.
REQ-007 reqReady  output  1: the block can accept a request this cycle.
REQ-008 pcEn  input  1: PC-enable returned by the stall counter; 0 means a stall is in progress.
REQ-009 delayEn  output  1: a one-cycle stall-start pulse to the stall counter.
REQ-010 delayLen  output  DELAY_W: the stall length, valid while delayEn=1.
REQ-011 busy  output  1: the queue is non-empty or the FSM is not in IDLE.
REQ-012 errTimeout  output  1: sticky flag; pcEn failed to fall within TIMEOUT cycles.
REQ-013 issuedCount  output  8: count of completed stalls; wraps 255->0.

Function
REQ-014 The block SHALL contain a 2-entry FIFO of reqCycles; a push occurs on any edge where reqValid=1 and reqReady=1.
REQ-015 reqReady SHALL equal !full, combinationally from FIFO occupancy; a pop in the same cycle does not raise reqReady (no push-when-full, even with a simultaneous pop).
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-017 IDLE, FIFO empty: stay in IDLE.
REQ-018 IDLE, head=0: pop the head and stay in IDLE; no pulse is issued and issuedCount is unchanged.
REQ-019 IDLE, head!=0: go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle, with delayEn=1 and delayLen=head; on exit, pop the head, clear the timeout counter, and go to WAIT_LOW.
REQ-021 delayEn SHALL be a Moore output equal to (state==ISSUE); delayLen SHALL be 0 whenever delayEn=0.
REQ-022 WAIT_LOW, pcEn=0: go to WAIT_HIGH.
REQ-023 WAIT_LOW, pcEn=1: increment the timeout counter; when it reaches TIMEOUT, set errTimeout, go to IDLE, and leave issuedCount unchanged.
REQ-024 WAIT_HIGH, pcEn=1: increment issuedCount (mod 256); go to ISSUE if the FIFO still holds a non-zero head at that edge, otherwise go to IDLE.
REQ-025 WAIT_HIGH, pcEn=0: stay in WAIT_HIGH indefinitely; no timeout applies in this state.
REQ-026 Latency: a request accepted at edge k into an empty FIFO with the FSM in IDLE SHALL produce delayEn=1 during the cycle following edge k+1.
REQ-027 Back-to-back requests SHALL be spaced by at least one WAIT_LOW cycle and one WAIT_HIGH cycle; at most one stall is outstanding at any time.
REQ-028 A push and a pop on the same edge SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-029 errTimeout SHALL be cleared only by reset.

Reset
REQ-030 While rstN=0 at a rising edge, the block SHALL set: state=IDLE, FIFO empty, timeout counter=0, delayEn=0, delayLen=0, busy=0, errTimeout=0, issuedCount=0.
REQ-031 A reset asserted mid-stall SHALL discard any queued and outstanding requests and emit no further pulses.
REQ-032 reqReady SHALL be 1 in the first cycle after reset is released.

Verification
REQ-033 Single request: push reqCycles=3 at edge 1; respond with pcEn low for 3 cycles starting 1 cycle after the pulse. Required: delayEn=1 for exactly one cycle with delayLen=3, then issuedCount=1 and busy=0.
REQ-034 Queue full: push 5, 2, 7 on consecutive cycles while pcEn is held at 0. Required: reqReady=0 after the second push, the third request is not accepted, and pulses carry delayLen 5 then 2.
REQ-035 Zero-length request: push 0 then 4. Required: one pulse only, with delayLen=4, and issuedCount=1.
REQ-036 Timeout: push 6 and hold pcEn=1 throughout. Required: errTimeout=1 exactly TIMEOUT cycles after the pulse, state returns to IDLE, and issuedCount=0.
REQ-037 Reset mid-stall: with 2 entries queued and the FSM in WAIT_HIGH, drive rstN=0 for one edge. Required: all outputs at reset values, and no delayEn after release.
REQ-038 Wrap: complete 256 stalls. Required: issuedCount returns to 0.
